// File: rtl/solitaire_move_sequencer.sv
// solitaire_move_sequencer
//   Queues (x, y, dir) move commands in a small FIFO and offers them one at a
//   time to the board core over mv_valid/mv_ready. After each hand-off it waits
//   for a legality response. A response or timeout ends the wait. Legal moves
//   are counted and rejected or timed-out moves are flagged. Once the core
//   raises game_over, the block flushes and freezes until rst.
//   Optional build macro: SOLITAIRE_SEQ_STATS_EN adds the rejects_o counter.
module solitaire_move_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   input  logic [2:0]       cmd_x_i,
   input  logic [2:0]       cmd_y_i,
   input  logic [1:0]       cmd_dir_i,
   output logic             cmd_ready_o,
   output logic             mv_valid_o,
   output logic [2:0]       mv_x_o,
   output logic [2:0]       mv_y_o,
   output logic [1:0]       mv_dir_o,
   input  logic             mv_ready_i,
   input  logic             rsp_valid_i,
   input  logic             rsp_legal_i,
   input  logic             game_over_i,
   output logic [CNT_W-1:0] moves_done_o,
   output logic             illegal_o,
   output logic             timeout_o,
   output logic             drop_o,
`ifdef SOLITAIRE_SEQ_STATS_EN
   output logic [CNT_W-1:0] rejects_o,
`endif
   output logic             busy_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t           state_q;
   logic [7:0]       mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [TW-1:0]    timer_q;
   logic [CNT_W-1:0] moves_q;
   logic             illegal_q, timeout_q, drop_q;
   logic             push, pop, flush, empty, full;
   logic [7:0]       head;
`ifdef SOLITAIRE_SEQ_STATS_EN
   logic [CNT_W-1:0] rejects_q;
`endif

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign empty       = (cnt_q == '0);
   assign full        = (cnt_q == CW'(DEPTH));
   // A full FIFO refuses the push even if the head pops in the same cycle.
   assign cmd_ready_o = !full && (state_q != HALT);
   assign push        = cmd_valid_i && cmd_ready_o;
   assign pop         = (state_q == ISSUE) && mv_ready_i;
   // Entering or sitting in HALT discards all queued commands,
   // including one pushed on the same edge.
   assign flush       = (state_q == HALT) ||
                        (game_over_i && ((state_q == IDLE) ||
                                         ((state_q == ISSUE) && !mv_ready_i)));

   // FIFO pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   // FIFO pointer and occupancy registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // FIFO storage; payload only, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_x_i, cmd_y_i, cmd_dir_i};
   end

   // Move sequencing FSM with its counters and one-cycle status pulses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         moves_q   <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         drop_q    <= 1'b0;
`ifdef SOLITAIRE_SEQ_STATS_EN
         rejects_q <= '0;
`endif
      end else begin
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         drop_q    <= cmd_valid_i && !cmd_ready_o;
         unique case (state_q)
            IDLE: begin
               if (game_over_i)  state_q <= HALT;
               else if (!empty)  state_q <= ISSUE;
            end
            ISSUE: begin
               if (mv_ready_i) begin
                  state_q <= WAIT;
                  timer_q <= '0;
               end else if (game_over_i) begin
                  state_q <= HALT;
               end
            end
            WAIT: begin
               if (rsp_valid_i) begin
                  if (rsp_legal_i) begin
                     moves_q <= sat_inc(moves_q);
                  end else begin
                     illegal_q <= 1'b1;
`ifdef SOLITAIRE_SEQ_STATS_EN
                     rejects_q <= sat_inc(rejects_q);
`endif
                  end
                  state_q <= IDLE;
               end else if (timer_q == TW'(TIMEOUT)) begin
                  timeout_q <= 1'b1;
`ifdef SOLITAIRE_SEQ_STATS_EN
                  rejects_q <= sat_inc(rejects_q);
`endif
                  state_q   <= IDLE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            HALT: state_q <= HALT;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign head         = mem_q[rd_ptr_q];
   assign mv_valid_o   = (state_q == ISSUE);
   // Coordinates read as zero while nothing is offered.
   assign mv_x_o       = mv_valid_o ? head[7:5] : 3'd0;
   assign mv_y_o       = mv_valid_o ? head[4:2] : 3'd0;
   assign mv_dir_o     = mv_valid_o ? head[1:0] : 2'd0;
   assign moves_done_o = moves_q;
   assign illegal_o    = illegal_q;
   assign timeout_o    = timeout_q;
   assign drop_o       = drop_q;
   assign busy_o       = (state_q != IDLE) || !empty;
`ifdef SOLITAIRE_SEQ_STATS_EN
   assign rejects_o    = rejects_q;
`endif

endmodule

// File: tb/tb_solitaire_move_sequencer.sv
// Bench for solitaire_move_sequencer: directed scenarios followed by random
// traffic. Every cycle is compared against a queue-based reference model.
module tb_solitaire_move_sequencer;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;
   localparam int CNT_W   = 6;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cmd_valid = 1'b0;
   logic [2:0]       cmd_x = '0;
   logic [2:0]       cmd_y = '0;
   logic [1:0]       cmd_dir = '0;
   logic             cmd_ready;
   logic             mv_valid;
   logic [2:0]       mv_x, mv_y;
   logic [1:0]       mv_dir;
   logic             mv_ready = 1'b0;
   logic             rsp_valid = 1'b0;
   logic             rsp_legal = 1'b0;
   logic             game_over = 1'b0;
   logic [CNT_W-1:0] moves_done;
   logic             illegal, timeout, drop, busy;
`ifdef SOLITAIRE_SEQ_STATS_EN
   logic [CNT_W-1:0] rejects;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pending commands, what the sequencer is doing, counters.
   logic [7:0] m_q[$];
   bit         m_offer, m_await, m_halt;
   int         m_wait, m_moves, m_rej;
   bit         m_ill, m_to, m_drop;

   solitaire_move_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cmd_valid_i  (cmd_valid),
      .cmd_x_i      (cmd_x),
      .cmd_y_i      (cmd_y),
      .cmd_dir_i    (cmd_dir),
      .cmd_ready_o  (cmd_ready),
      .mv_valid_o   (mv_valid),
      .mv_x_o       (mv_x),
      .mv_y_o       (mv_y),
      .mv_dir_o     (mv_dir),
      .mv_ready_i   (mv_ready),
      .rsp_valid_i  (rsp_valid),
      .rsp_legal_i  (rsp_legal),
      .game_over_i  (game_over),
      .moves_done_o (moves_done),
      .illegal_o    (illegal),
      .timeout_o    (timeout),
      .drop_o       (drop),
`ifdef SOLITAIRE_SEQ_STATS_EN
      .rejects_o    (rejects),
`endif
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // One clock edge of the behavioural model, from the inputs seen at that edge.
   task automatic model_step(input logic r, input logic cv, input logic [7:0] cmd,
                             input logic mr, input logic rv, input logic rl, input logic go);
      bit ready, halt_now;
      int had;
      if (r) begin
         m_q.delete();
         m_offer = 0; m_await = 0; m_halt = 0; m_wait = 0;
         m_moves = 0; m_rej = 0; m_ill = 0; m_to = 0; m_drop = 0;
         return;
      end
      ready    = (m_q.size() < DEPTH) && !m_halt;
      m_drop   = cv && !ready;
      m_ill    = 0;
      m_to     = 0;
      halt_now = 0;
      had      = m_q.size();
      if (m_halt) begin
         halt_now = 0;
      end else if (m_offer) begin
         if (mr) begin
            void'(m_q.pop_front());
            m_offer = 0; m_await = 1; m_wait = 0;
         end else if (go) begin
            halt_now = 1;
         end
      end else if (m_await) begin
         if (rv) begin
            if (rl) m_moves = (m_moves < CNT_MAX) ? m_moves + 1 : m_moves;
            else begin
               m_ill = 1;
               m_rej = (m_rej < CNT_MAX) ? m_rej + 1 : m_rej;
            end
            m_await = 0;
         end else if (m_wait == TIMEOUT) begin
            m_to = 1;
            m_rej = (m_rej < CNT_MAX) ? m_rej + 1 : m_rej;
            m_await = 0;
         end else begin
            m_wait++;
         end
      end else begin
         if (go) halt_now = 1;
         else if (had > 0) m_offer = 1;
      end
      if (cv && ready) m_q.push_back(cmd);
      if (halt_now) begin
         m_halt = 1; m_offer = 0;
         m_q.delete();
      end
   endtask

   task automatic check_all();
      logic [7:0] h;
      bit er, eb;
      er = (m_q.size() < DEPTH) && !m_halt;
      eb = m_offer || m_await || m_halt || (m_q.size() > 0);
      chk("cmd_ready", 32'(cmd_ready), 32'(er));
      chk("mv_valid", 32'(mv_valid), 32'(m_offer));
      if (m_offer) begin
         h = m_q[0];
         chk("mv_x", 32'(mv_x), 32'(h[7:5]));
         chk("mv_y", 32'(mv_y), 32'(h[4:2]));
         chk("mv_dir", 32'(mv_dir), 32'(h[1:0]));
      end
      chk("moves_done", 32'(moves_done), 32'(m_moves));
      chk("illegal", 32'(illegal), 32'(m_ill));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("drop", 32'(drop), 32'(m_drop));
      chk("busy", 32'(busy), 32'(eb));
`ifdef SOLITAIRE_SEQ_STATS_EN
      chk("rejects", 32'(rejects), 32'(m_rej));
`endif
   endtask

   task automatic cycle(input logic r, input logic cv, input logic [2:0] x, input logic [2:0] y,
                        input logic [1:0] d, input logic mr, input logic rv, input logic rl,
                        input logic go);
      rst = r; cmd_valid = cv; cmd_x = x; cmd_y = y; cmd_dir = d;
      mv_ready = mr; rsp_valid = rv; rsp_legal = rl; game_over = go;
      @(posedge clk);
      model_step(r, cv, {x, y, d}, mr, rv, rl, go);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push_cmd(input logic [2:0] x, input logic [2:0] y, input logic [1:0] d);
      cycle(1'b0, 1'b1, x, y, d, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int  n;
      bit  seen;
      int  rsp_pct;
      logic r, go;

      @(negedge clk);
      do_reset();
      chk("rst_mv_x", 32'(mv_x), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);

      // Single legal move
      push_cmd(3'd2, 3'd3, 2'd1);
      idle();
      chk("t1_mv_valid", 32'(mv_valid), 32'd1);
      chk("t1_mv_x", 32'(mv_x), 32'd2);
      chk("t1_mv_y", 32'(mv_y), 32'd3);
      chk("t1_mv_dir", 32'(mv_dir), 32'd1);
      cycle(1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      cycle(1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t1_moves", 32'(moves_done), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);

      // Fill the FIFO with the core stalled
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push_cmd(3'(i + 1), 3'(6 - i), 2'(i));
         if (i == 2) chk("t2_ready_3", 32'(cmd_ready), 32'd1);
         if (i == 3) chk("t2_ready_4", 32'(cmd_ready), 32'd0);
      end
      chk("t2_drop", 32'(drop), 32'd1);
      chk("t2_hold_x", 32'(mv_x), 32'd1);
      chk("t2_hold_y", 32'(mv_y), 32'd6);
      chk("t2_hold_dir", 32'(mv_dir), 32'd0);
      idle();
      chk("t2_drop_once", 32'(drop), 32'd0);

      // Response timeout
      do_reset();
      push_cmd(3'd4, 3'd1, 2'd2);
      idle();
      cycle(1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n = 0; seen = 0;
      while (!seen && n < 40) begin
         idle();
         n++;
         if (timeout) seen = 1;
      end
      chk("t3_timeout_seen", 32'(seen), 32'd1);
      chk("t3_timeout_lat", 32'(n), 32'(TIMEOUT + 1));
      chk("t3_moves", 32'(moves_done), 32'd0);
      push_cmd(3'd6, 3'd5, 2'd3);
      idle();
      chk("t3_next_valid", 32'(mv_valid), 32'd1);
      chk("t3_next_x", 32'(mv_x), 32'd6);

      // Illegal move
      do_reset();
      push_cmd(3'd4, 3'd4, 2'd2);
      idle();
      cycle(1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4_illegal", 32'(illegal), 32'd1);
      chk("t4_moves", 32'(moves_done), 32'd0);
`ifdef SOLITAIRE_SEQ_STATS_EN
      chk("t4_rejects", 32'(rejects), 32'd1);
`endif
      idle();
      chk("t4_illegal_end", 32'(illegal), 32'd0);

      // Game over while offering with commands queued
      do_reset();
      for (int i = 0; i < 4; i++) push_cmd(3'(i), 3'(i), 2'(i));
      chk("t5_issue", 32'(mv_valid), 32'd1);
      cycle(1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5_mv_drop", 32'(mv_valid), 32'd0);
      chk("t5_ready", 32'(cmd_ready), 32'd0);
      cycle(1'b0, 1'b1, 3'd1, 3'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5_drop", 32'(drop), 32'd1);
      cycle(1'b1, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_rst_ready", 32'(cmd_ready), 32'd1);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_valid", 32'(mv_valid), 32'd0);
      chk("t5_rst_drop", 32'(drop), 32'd0);

      // moves_done saturation
      do_reset();
      for (int i = 0; i < 64; i++) begin
         push_cmd(3'(i), 3'(i >> 3), 2'(i));
         idle();
         cycle(1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
         cycle(1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      end
      chk("t6_saturate", 32'(moves_done), 32'(CNT_MAX));

      // Random traffic against the model
      do_reset();
      for (int blk = 0; blk < 15; blk++) begin
         rsp_pct = (blk % 3 == 0) ? 2 : 30;
         for (int i = 0; i < 200; i++) begin
            r  = (m_halt && ($urandom_range(0, 7) == 0)) || ($urandom_range(0, 499) == 0);
            go = ($urandom_range(0, 299) == 0);
            cycle(r, ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) < rsp_pct),
                  ($urandom_range(0, 3) != 0), go);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
